// File: rtl/serial_ctrl_pkg.sv
// Shared types and width helpers for the serial capture controller.
package serial_ctrl_pkg;

    typedef enum logic {IDLE, SHIFT} cap_state_t;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned DIV_DEFAULT   = 2097152;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running clock-enable divider: one-cycle tick every DIV enabled cycles.
module tick_prescaler
    import serial_ctrl_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned    PW   = cnt_width(DIV);
    localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    always_comb begin
        presc_d = presc_q;
        if (clr) begin
            presc_d = '0;
        end else if (en) begin
            presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    assign tick = en && (presc_q == LAST);

endmodule

// File: rtl/serial_capture_ctrl.sv
// Serial-to-parallel capture sequencer: ticked shift register, frame counter,
// single-word valid/ready output buffer and sticky overrun flag.
module serial_capture_ctrl
    import serial_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned DIV   = DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             start_i,
    input  logic             cont_i,
    input  logic             abort_i,
    input  logic             ready_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] word_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             tick_o,
    output logic             overrun_o
);

    localparam int unsigned   BW       = cnt_width(WIDTH);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    cap_state_t       state_q, state_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic             busy;
    logic             arm;
    logic             tick;
    logic             done;
    logic             ovr_set;
    logic [WIDTH-1:0] shifted;

    assign busy    = (state_q == SHIFT);
    assign arm     = (state_q == IDLE) && start_i;
    assign shifted = {sreg_q[WIDTH-2:0], serial_in};

    tick_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .clr   (arm),
        .tick  (tick)
    );

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sreg_d   = sreg_q;
        word_d   = word_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        done     = 1'b0;
        ovr_set  = 1'b0;

        if (arm) begin
            state_d  = SHIFT;
            bitcnt_d = '0;
        end else if (busy) begin
            // Abort beats a coinciding completion: the frame is simply dropped.
            if (abort_i) begin
                state_d = IDLE;
            end else if (tick) begin
                sreg_d = shifted;
                if (bitcnt_q == BIT_LAST) begin
                    bitcnt_d = '0;
                    done     = 1'b1;
                    if (!cont_i) begin
                        state_d = IDLE;
                    end
                end else begin
                    bitcnt_d = bitcnt_q + BW'(1);
                end
            end
        end

        if (done) begin
            if (!valid_q || ready_i) begin
                word_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clr_i) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            sreg_q   <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sreg_q   <= sreg_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign word_o    = word_q;
    assign valid_o   = valid_q;
    assign busy_o    = busy;
    assign tick_o    = tick;
    assign overrun_o = ovr_q;

endmodule
